// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule.
// Takes a cipher key and produces one round key per accepted beat on a
// valid/ready stream. Every round key is also written to a bank that can be
// read by index, for decryption and key reuse. SubWord comes from an
// external combinational S-box: this block sends RotWord(w3) on sbox_in and
// gets the substituted word back on sbox_out in the same cycle.
module aes_key_expander #(
    parameter int          NUM_ROUNDS = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01,
    parameter int          IDX_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       key_in,
    output logic [31:0]        sbox_in,
    input  logic [31:0]        sbox_out,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [127:0]       rk_data,
    output logic [IDX_W-1:0]   rk_round,
    output logic               busy,
    output logic               done,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [127:0]       rd_data
);

    localparam int DEPTH = 1 << IDX_W;

    // FINISH is the single cycle that carries the done pulse. It accepts a
    // new start exactly like IDLE does.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [127:0]     cur_key_reg;
    logic [7:0]       rcon_reg;
    logic [IDX_W-1:0] round_reg;

    logic             start_ok;
    logic             accept;
    logic             last_round;
    logic             advance;

    logic [31:0]      cur_w  [4];
    logic [31:0]      next_w [4];
    logic [127:0]     next_key;
    logic [31:0]      t_word;
    logic [7:0]       rcon_xtime;

    logic [127:0]     bank [DEPTH];
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [127:0]     wr_data;

    // start counts only when the FSM is not streaming. That also covers a
    // start that arrives in the same cycle as the final accept.
    assign start_ok   = start && (state_reg != STREAM);
    assign accept     = rk_valid && rk_ready;
    assign last_round = (round_reg == IDX_W'(NUM_ROUNDS));
    assign advance    = accept && !last_round;

    // Next-round arithmetic. t is SubWord(RotWord(w3)) xor rcon, and each
    // new word chains onto the one before it.
    assign sbox_in    = {cur_key_reg[23:0], cur_key_reg[31:24]};
    assign t_word     = sbox_out ^ {rcon_reg, 24'h000000};
    assign rcon_xtime = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_words
            assign cur_w[gi] = cur_key_reg[127 - 32*gi -: 32];
            if (gi == 0) begin : g_first
                assign next_w[gi] = cur_w[gi] ^ t_word;
            end else begin : g_chain
                assign next_w[gi] = next_w[gi-1] ^ cur_w[gi];
            end
            assign next_key[127 - 32*gi -: 32] = next_w[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = STREAM;
            STREAM:  if (accept && last_round) state_next = FINISH;
            FINISH:  state_next = start_ok ? STREAM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode. Every output comes straight from the registered state,
    // so reset clears them as soon as it is asserted.
    always_comb begin
        rk_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_reg)
            STREAM:  begin rk_valid = 1'b1; busy = 1'b1; end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // Current key, round counter and rcon. All three hold while the
    // consumer stalls the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_key_reg <= '0;
            round_reg   <= '0;
            rcon_reg    <= RCON_INIT;
        end else if (start_ok) begin
            cur_key_reg <= key_in;
            round_reg   <= '0;
            rcon_reg    <= RCON_INIT;
        end else if (advance) begin
            cur_key_reg <= next_key;
            round_reg   <= round_reg + IDX_W'(1);
            rcon_reg    <= rcon_xtime;
        end
    end

    assign rk_data  = cur_key_reg;
    assign rk_round = round_reg;

    // Bank write port. start_ok and advance can never be true together.
    assign wr_en   = start_ok || advance;
    assign wr_addr = start_ok ? '0 : round_reg + IDX_W'(1);
    assign wr_data = start_ok ? key_in : next_key;

    // Bank storage. No reset, so the tools can map it to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank[wr_addr] <= wr_data;
        end
    end

    // Registered read port. A write to the same index in the same cycle
    // returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= bank[rd_idx];
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: a full-length instance and a 3-round
// instance, a behavioural FIPS-197 key-expansion model, and a per-cycle
// stream check.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, start3 = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b1;
    logic [3:0]   rd_idx = '0;

    logic [31:0]  sbox_in, sbox_out, sbox_in3, sbox_out3;
    logic         rk_valid, busy, done, rk_valid3, busy3, done3;
    logic [127:0] rk_data, rd_data, rk_data3, rd_data3;
    logic [3:0]   rk_round, rk_round3;

    always #5 clk = ~clk;

    logic [7:0] sbox_tab [256];
    assign sbox_out  = {sbox_tab[sbox_in[31:24]], sbox_tab[sbox_in[23:16]],
                        sbox_tab[sbox_in[15:8]],  sbox_tab[sbox_in[7:0]]};
    assign sbox_out3 = {sbox_tab[sbox_in3[31:24]], sbox_tab[sbox_in3[23:16]],
                        sbox_tab[sbox_in3[15:8]],  sbox_tab[sbox_in3[7:0]]};

    aes_key_expander #(.NUM_ROUNDS(10), .RCON_INIT(8'h01), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .sbox_in(sbox_in), .sbox_out(sbox_out),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_round(rk_round), .busy(busy), .done(done),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    aes_key_expander #(.NUM_ROUNDS(3), .RCON_INIT(8'h01), .IDX_W(4)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .key_in(key_in),
        .sbox_in(sbox_in3), .sbox_out(sbox_out3),
        .rk_valid(rk_valid3), .rk_ready(rk_ready), .rk_data(rk_data3),
        .rk_round(rk_round3), .busy(busy3), .done(done3),
        .rd_idx(rd_idx), .rd_data(rd_data3)
    );

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2 = 128'h5468617473206d79204b756e67204675;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] mk [11];

    int           exp_round  [2];
    int           beats      [2];
    logic         prev_valid [2];
    logic         prev_stall [2];
    logic         last_final [2];
    logic [127:0] prev_data  [2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // The S-box is built from first principles: GF(2^8) inverse followed
    // by the affine transform.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            logic [7:0] av;
            av  = 8'(a);
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Textbook FIPS-197 expansion: a flat 44-word array, with rcon taken
    // as successive powers of 2 in GF(2^8).
    task automatic set_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [7:0]  rc [10];
        logic [31:0] tmp;
        rc[0] = 8'h01;
        for (int j = 1; j < 10; j++) rc[j] = gmul(rc[j-1], 8'h02);
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0)
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc[i/4 - 1], 24'h0};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Per-cycle stream check for both instances. It tracks which round must
    // be showing, whether a stall must hold the data, and when done is due.
    task automatic monitor();
        for (int d = 0; d < 2; d++) begin
            logic         v, b, dn;
            logic [3:0]   r;
            logic [127:0] dt;
            int           nr;
            v  = d ? rk_valid3 : rk_valid;
            b  = d ? busy3     : busy;
            dn = d ? done3     : done;
            r  = d ? rk_round3 : rk_round;
            dt = d ? rk_data3  : rk_data;
            nr = d ? 3 : 10;
            chk(d ? "done3_timing" : "done_timing", 128'(dn), 128'(last_final[d]));
            chk(d ? "busy3" : "busy", 128'(b), 128'(v));
            last_final[d] = 1'b0;
            if (v) begin
                if (!prev_valid[d]) exp_round[d] = 0;
                chk(d ? "rk_round3" : "rk_round", 128'(r), 128'(exp_round[d]));
                if (exp_round[d] <= nr)
                    chk(d ? "rk_data3" : "rk_data", dt, mk[exp_round[d]]);
                if (prev_stall[d]) chk(d ? "stall_hold3" : "stall_hold", dt, prev_data[d]);
                if (rk_ready) begin
                    beats[d]++;
                    $display("beat dut%0d round %0d data %h", d ? 3 : 10, r, dt);
                    if (exp_round[d] == nr) last_final[d] = 1'b1;
                    else exp_round[d]++;
                end
            end
            prev_valid[d] = v;
            prev_stall[d] = v && !rk_ready;
            prev_data[d]  = dt;
        end
    endtask

    // One clock: check at the falling edge, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k, input bit three);
        key_in = k;
        set_model(k);
        if (three) start3 = 1'b1; else start = 1'b1;
        cycle();
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    // Returns the cycle on which done is seen, counting the start cycle as 0.
    task automatic wait_done(input int budget, input bit random_ready, output int lat);
        lat = 1;
        while (!done) begin
            if (lat >= budget) begin
                lat = -1;
                return;
            end
            if (random_ready) rk_ready = 1'($urandom_range(0, 1));
            cycle();
            lat++;
        end
        rk_ready = 1'b1;
    endtask

    initial begin
        int lat, b0, n;
        for (int d = 0; d < 2; d++) begin
            exp_round[d] = 0; beats[d] = 0; prev_valid[d] = 0;
            prev_stall[d] = 0; last_final[d] = 0; prev_data[d] = '0;
        end
        build_sbox();
        chk("sbox_00", 128'(sbox_tab[8'h00]), 128'h63);
        chk("sbox_53", 128'(sbox_tab[8'h53]), 128'hed);
        chk("sbox_ff", 128'(sbox_tab[8'hff]), 128'h16);

        // Reset state
        cycle();
        chk("rst_valid", 128'(rk_valid), 128'h0);
        chk("rst_busy",  128'(busy),     128'h0);
        chk("rst_done",  128'(done),     128'h0);
        chk("rst_data",  rk_data,        128'h0);
        chk("rst_round", 128'(rk_round), 128'h0);
        chk("rst_rd",    rd_data,        128'h0);
        rst = 1'b0;
        cycle();

        // FIPS-197 key, consumer always ready
        do_start(KEY1, 1'b0);
        chk("pin1_r1",  mk[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("pin1_r10", mk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("start_r0", rk_data, KEY1);
        wait_done(40, 1'b0, lat);
        chk("done_latency1", 128'(lat), 128'd12);
        cycle();
        chk("idle_after_done", 128'(rk_valid), 128'h0);

        // Bank sweep, one-cycle read latency
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            cycle();
            chk("bank_read", rd_data, mk[i]);
            $display("read idx %0d data %h", i, rd_data);
        end

        // Second key
        do_start(KEY2, 1'b0);
        chk("pin2_r1",  mk[1],  128'he232fcf191129188b159e4e6d679a293);
        chk("pin2_r10", mk[10], 128'h28fddef86da4244accc0a4fe3b316f26);
        wait_done(40, 1'b0, lat);
        chk("done_latency2", 128'(lat), 128'd12);
        cycle();

        // Random backpressure: exactly 11 beats, with data held while stalled
        b0 = beats[0];
        do_start(KEY1, 1'b0);
        wait_done(400, 1'b1, lat);
        chk("stall_done_seen", 128'(lat > 0), 128'h1);
        chk("stall_beats", 128'(beats[0] - b0), 128'd11);
        cycle();

        // start in the middle of a run is ignored; reset then aborts the run
        do_start(KEY1, 1'b0);
        n = 0;
        while (!(rk_valid && rk_round == 4'd4) && n < 20) begin cycle(); n++; end
        chk("reach_round4", 128'(rk_round), 128'd4);
        key_in = KEY2;
        start  = 1'b1;
        cycle();
        start  = 1'b0;
        chk("ignored_start", 128'(rk_round), 128'd5);
        n = 0;
        while (!(rk_valid && rk_round == 4'd6) && n < 20) begin cycle(); n++; end
        chk("reach_round6", 128'(rk_round), 128'd6);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 128'(rk_valid), 128'h0);
        chk("async_busy",  128'(busy),     128'h0);
        chk("async_data",  rk_data,        128'h0);
        chk("async_round", 128'(rk_round), 128'h0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        do_start(KEY2, 1'b0);
        chk("restart_r0", rk_data, KEY2);
        chk("restart_valid", 128'(rk_valid), 128'h1);
        wait_done(40, 1'b0, lat);
        chk("done_latency3", 128'(lat), 128'd12);
        cycle();

        // Three-round build; start on the final accept must be ignored
        b0 = beats[1];
        do_start(KEY1, 1'b1);
        n = 1;
        while (!(rk_valid3 && rk_round3 == 4'd3) && n < 20) begin cycle(); n++; end
        chk("r3_last_cycle", 128'(n), 128'd4);
        start3 = 1'b1;
        cycle();
        start3 = 1'b0;
        chk("r3_done", 128'(done3), 128'h1);
        chk("r3_start_on_final", 128'(rk_valid3), 128'h0);
        cycle();
        chk("r3_idle", 128'(rk_valid3), 128'h0);
        chk("r3_beats", 128'(beats[1] - b0), 128'd4);
        for (int i = 0; i <= 3; i++) begin
            rd_idx = 4'(i);
            cycle();
            chk("bank3_read", rd_data3, mk[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
